// File: rtl/mem_pkg.sv
// Shared definitions for the RAM port arbiter: FSM states, port ids and
// default geometry.
package mem_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int WD_W        = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef logic port_t;
  localparam port_t PORT_I = 1'b0;
  localparam port_t PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the side that was not granted last
// wins; a lone request always wins.
module rr_arb2
  import mem_pkg::*;
(
  input  logic  i_req,
  input  logic  d_req,
  input  port_t last_grant,
  output logic  gnt_valid,
  output port_t gnt_id
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    gnt_valid = i_req | d_req;
    gnt_id    = PORT_I;
    if (i_req && d_req) begin
      gnt_id = (last_grant == PORT_D) ? PORT_I : PORT_D;
    end else if (d_req) begin
      gnt_id = PORT_D;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM port between instruction refills and data accesses with a
// registered command, round-robin arbitration and a sticky watchdog abort.
module ram_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              timeout_err
);

  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  state_t          state;
  port_t           last_grant;
  logic [WD_W-1:0] wd_cnt;
  logic            gnt_valid;
  port_t           gnt_id;
  logic            busy;
  logic            timeout_hit;
  logic            done;

  rr_arb2 u_rr_arb2 (
    .i_req      (i_req),
    .d_req      (d_req),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // A RAM answer on the limit cycle wins over the abort.
  assign busy        = (state == BUSY_I) || (state == BUSY_D);
  assign timeout_hit = busy && !ram_ready && (wd_cnt == WD_LIMIT);
  assign done        = busy && (ram_ready || timeout_hit);

  assign i_ready = (state == BUSY_I) && (ram_ready || timeout_hit);
  assign d_ready = (state == BUSY_D) && (ram_ready || timeout_hit);
  assign i_rdata = ((state == BUSY_I) && !timeout_hit) ? ram_rdata : '0;
  assign d_rdata = ((state == BUSY_D) && !ram_write && !timeout_hit) ? ram_rdata : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_grant  <= PORT_D;
      wd_cnt      <= '0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            last_grant <= gnt_id;
            wd_cnt     <= '0;
            if (gnt_id == PORT_I) begin
              state     <= BUSY_I;
              ram_addr  <= i_addr;
              ram_read  <= 1'b1;
              ram_write <= 1'b0;
            end else begin
              state     <= BUSY_D;
              ram_addr  <= d_addr;
              ram_read  <= !d_we;
              ram_write <= d_we;
              if (d_we) ram_wdata <= d_wdata;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (done) begin
            state     <= IDLE;
            ram_read  <= 1'b0;
            ram_write <= 1'b0;
            if (timeout_hit) timeout_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a transaction-level model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ram_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_we, ram_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, ram_rdata;
  logic [DW-1:0] i_rdata, d_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic          i_ready, d_ready, ram_read, ram_write, timeout_err;

  int vectors = 0;
  int miscompares = 0;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_ready     (i_ready),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ready     (d_ready),
    .ram_read    (ram_read),
    .ram_write   (ram_write),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .ram_ready   (ram_ready),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: owner 0 = none, 1 = instruction side, 2 = data side.
  int            m_owner, m_last, m_age, m_pick;
  logic          m_we, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_owner = 0; m_last = 2; m_age = 0; m_we = 1'b0; m_err = 1'b0;
      m_addr = '0; m_wdata = '0;
    end else if (m_owner == 0) begin
      m_pick = 0;
      if (i_req && d_req) m_pick = (m_last == 2) ? 1 : 2;
      else if (i_req)     m_pick = 1;
      else if (d_req)     m_pick = 2;
      if (m_pick != 0) begin
        m_owner = m_pick;
        m_last  = m_pick;
        m_age   = 0;
        m_we    = (m_pick == 2) && d_we;
        m_addr  = (m_pick == 1) ? i_addr : d_addr;
        if (m_we) m_wdata = d_wdata;
      end
    end else begin
      if (ram_ready) m_owner = 0;
      else if (m_age == TO) begin m_owner = 0; m_err = 1'b1; end
      else m_age++;
    end
  end

  always @(negedge clock) begin
    logic abort;
    abort = (m_owner != 0) && !ram_ready && (m_age == TO);
    check("ram_read",  ram_read,  (m_owner == 1) || (m_owner == 2 && !m_we));
    check("ram_write", ram_write, (m_owner == 2) && m_we);
    check("ram_addr",  ram_addr,  m_addr);
    check("ram_wdata", ram_wdata, m_wdata);
    check("i_ready",   i_ready,   (m_owner == 1) && (ram_ready || abort));
    check("d_ready",   d_ready,   (m_owner == 2) && (ram_ready || abort));
    check("i_rdata",   i_rdata,   (m_owner == 1 && !abort) ? ram_rdata : '0);
    check("d_rdata",   d_rdata,   (m_owner == 2 && !m_we && !abort) ? ram_rdata : '0);
    check("timeout_err", timeout_err, m_err);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset = 1'b0; i_req = 0; d_req = 0; d_we = 0; ram_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; ram_rdata = '0;
    tick(); tick();
    check("rst_ram_read", ram_read, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_err", timeout_err, 0);
    reset = 1'b1;

    // Single instruction read answered on the third busy cycle.
    i_req = 1; i_addr = 32'h40; ram_rdata = 32'h0BAD0BAD;
    tick(); #3;
    check("t1_read", ram_read, 1);
    check("t1_addr", ram_addr, 32'h40);
    check("t1_noready", i_ready, 0);
    tick(); tick();
    ram_ready = 1; ram_rdata = 32'hDEADBEEF; #3;
    check("t1_ready", i_ready, 1);
    check("t1_rdata", i_rdata, 32'hDEADBEEF);
    tick();
    i_req = 0; ram_ready = 0; #3;
    check("t1_read_drop", ram_read, 0);
    check("t1_ready_drop", i_ready, 0);

    // Both requests held: grants alternate I, D, I, D; ram_ready idle-high.
    do_reset();
    i_req = 1; i_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h100;
    ram_ready = 1; ram_rdata = 32'h5A5A0001;
    for (int k = 0; k < 4; k++) begin
      tick(); #3;
      check("t2_i_ready", i_ready, (k % 2) == 0);
      check("t2_d_ready", d_ready, (k % 2) == 1);
      check("t2_addr", ram_addr, ((k % 2) == 0) ? 32'h200 : 32'h100);
      tick(); #3;
      check("t2_idle_ready", i_ready | d_ready, 0);
    end
    i_req = 0; d_req = 0; ram_ready = 0;

    // Data write: command held while the requester inputs change.
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = 32'h12345678;
    tick(); #3;
    check("t3_write", ram_write, 1);
    d_addr = 32'hFFF0; d_wdata = 32'h0; d_we = 0;
    tick(); #3;
    check("t3_addr_held", ram_addr, 32'h80);
    check("t3_wdata_held", ram_wdata, 32'h12345678);
    check("t3_write_held", ram_write, 1);
    tick();
    ram_ready = 1; ram_rdata = 32'hAAAA5555; #3;
    check("t3_ready", d_ready, 1);
    check("t3_rdata", d_rdata, 0);
    tick();
    d_req = 0; ram_ready = 0;

    // Watchdog abort after TO busy cycles; error stays set afterwards.
    tick();
    i_req = 1; i_addr = 32'h300; ram_rdata = 32'hBADBAD00;
    tick();
    for (int k = 0; k < TO; k++) begin
      #3 check("t4_wait", i_ready, 0);
      tick();
    end
    #3;
    check("t4_abort_ready", i_ready, 1);
    check("t4_abort_rdata", i_rdata, 0);
    check("t4_err_before", timeout_err, 0);
    tick();
    i_req = 0; #3;
    check("t4_err_set", timeout_err, 1);
    check("t4_cmd_drop", ram_read, 0);
    d_req = 1; d_we = 0; d_addr = 32'h44;
    tick();
    ram_ready = 1; ram_rdata = 32'h0F0F0F0F; #3;
    check("t4_ok_ready", d_ready, 1);
    check("t4_ok_rdata", d_rdata, 32'h0F0F0F0F);
    tick();
    d_req = 0; ram_ready = 0; #3;
    check("t4_err_sticky", timeout_err, 1);

    // RAM answers on the exact limit cycle: normal completion.
    do_reset();
    i_req = 1; i_addr = 32'h340;
    tick();
    for (int k = 0; k < TO; k++) tick();
    ram_ready = 1; ram_rdata = 32'hCAFEF00D; #3;
    check("t5_ready", i_ready, 1);
    check("t5_rdata", i_rdata, 32'hCAFEF00D);
    tick();
    i_req = 0; ram_ready = 0; #3;
    check("t5_no_err", timeout_err, 0);

    // Reset mid-transaction drops the command at once with no ready pulse.
    tick();
    d_req = 1; d_we = 1; d_addr = 32'h500; d_wdata = 32'h55AA55AA;
    tick(); #3;
    check("t6_write", ram_write, 1);
    tick(); #2;
    reset = 1'b0; ram_ready = 1; #1;
    check("t6_write_drop", ram_write, 0);
    check("t6_read_drop", ram_read, 0);
    check("t6_no_ready", d_ready, 0);
    check("t6_addr_clr", ram_addr, 0);
    d_req = 0; ram_ready = 0;
    tick();
    reset = 1'b1;
    d_req = 1; d_we = 0; d_addr = 32'h600;
    tick(); #3;
    check("t6_fresh_read", ram_read, 1);
    check("t6_fresh_addr", ram_addr, 32'h600);
    tick();
    ram_ready = 1; ram_rdata = 32'h600DDA7A; #3;
    check("t6_fresh_ready", d_ready, 1);
    check("t6_fresh_rdata", d_rdata, 32'h600DDA7A);
    tick();
    d_req = 0; ram_ready = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
